// File: rtl/cmult_pkg.sv
// rtl/cmult_pkg.sv - shared FSM encodings, operand field widths and defaults
// for the complex multiplier arbiter
package cmult_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int RE_W            = 4;
   localparam int IM_W            = 4;
   localparam int DEF_WDOG_CYCLES = 64;

   typedef struct packed {
      logic [RE_W-1:0] re;
      logic [IM_W-1:0] im;
   } cpx_op_t;

   // Round-robin successor of a requester index, wrapping n-1 -> 0.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cmpx_mult_arbiter_if.sv
// rtl/cmpx_mult_arbiter_if.sv - requester and multiplier signals of the arbiter
// master = requesters plus multiplier side, slave = arbiter
interface cmpx_mult_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int RW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rsp_valid;
   logic [RW-1:0]      rsp_real;
   logic [RW-1:0]      rsp_imag;
   logic               rsp_err;
   logic               busy;
   logic               mult_start;
   logic [DW-1:0]      mult_a;
   logic [DW-1:0]      mult_b;
   logic               mult_done;
   logic [RW-1:0]      mult_real;
   logic [RW-1:0]      mult_imag;

   modport master (
      output req, req_a, req_b, mult_done, mult_real, mult_imag,
      input  gnt, rsp_valid, rsp_real, rsp_imag, rsp_err, busy,
             mult_start, mult_a, mult_b
   );

   modport slave (
      input  req, req_a, req_b, mult_done, mult_real, mult_imag,
      output gnt, rsp_valid, rsp_real, rsp_imag, rsp_err, busy,
             mult_start, mult_a, mult_b
   );
endinterface

// File: rtl/rr_arb_pick.sv
// rtl/rr_arb_pick.sv - combinational round-robin pick: first set req at or after ptr
module rr_arb_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic [PW-1:0]   idx,
   output logic            any
);
   always_comb begin
      int j;
      winner = '0;
      idx    = '0;
      any    = 1'b0;
      j      = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            winner[j] = 1'b1;
            idx       = PW'(j);
         end
      end
   end
endmodule

// File: rtl/cmpx_mult_arbiter.sv
// rtl/cmpx_mult_arbiter.sv - round-robin sharing of one complex multiplier among NREQ lanes
// optional WAIT-state timeout enabled by defining CMULT_ARB_WDOG_EN
module cmpx_mult_arbiter
   import cmult_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int DW          = RE_W + IM_W,
   parameter int RW          = 8,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   cmpx_mult_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]      state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic [RW-1:0]   real_q;
   logic [RW-1:0]   imag_q;
   logic            timeout;

   logic [NREQ-1:0] pick_oh;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;

   rr_arb_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .winner (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

`ifdef CMULT_ARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES + 1);

   logic [CW-1:0] wdog;
   logic          err_q;

   // Fires on the WDOG_CYCLES-th WAIT cycle that still has no done.
   assign timeout = (state == ST_WAIT) && !bus.mult_done && (wdog == CW'(WDOG_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog  <= '0;
         err_q <= 1'b0;
      end else if (state == ST_ISSUE) begin
         wdog  <= '0;
      end else if (state == ST_WAIT) begin
         wdog <= wdog + 1'b1;
         if (bus.mult_done)
            err_q <= 1'b0;
         else if (timeout)
            err_q <= 1'b1;
      end
   end

   assign bus.rsp_err = err_q;
`else
   assign timeout     = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         win_idx <= '0;
         win_oh  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         real_q  <= '0;
         imag_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  win_idx <= pick_idx;
                  win_oh  <= pick_oh;
                  a_q     <= bus.req_a[pick_idx*DW +: DW];
                  b_q     <= bus.req_b[pick_idx*DW +: DW];
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: state <= ST_WAIT;
            ST_WAIT: begin
               if (bus.mult_done) begin
                  real_q <= bus.mult_real;
                  imag_q <= bus.mult_imag;
                  state  <= ST_RESP;
               end else if (timeout) begin
                  real_q <= '0;
                  imag_q <= '0;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               ptr   <= PW'(rr_next(int'(win_idx), NREQ));
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Every output decodes registered state only, so async reset clears them at once.
   assign bus.busy       = (state != ST_IDLE);
   assign bus.gnt        = bus.busy ? win_oh : '0;
   assign bus.mult_start = (state == ST_ISSUE);
   assign bus.rsp_valid  = (state == ST_RESP) ? win_oh : '0;
   assign bus.mult_a     = a_q;
   assign bus.mult_b     = b_q;
   assign bus.rsp_real   = real_q;
   assign bus.rsp_imag   = imag_q;

endmodule

// File: tb/tb_cmpx_mult_arbiter.sv
// tb/tb_cmpx_mult_arbiter.sv - self-checking bench for cmpx_mult_arbiter
module tb_cmpx_mult_arbiter;
   import cmult_pkg::*;

   localparam int N        = 4;
   localparam int DW       = 8;
   localparam int RW       = 8;
   localparam int MULT_LAT = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmpx_mult_arbiter_if #(.NREQ(N), .DW(DW), .RW(RW)) bus ();

   cmpx_mult_arbiter #(.NREQ(N), .DW(DW), .RW(RW), .WDOG_CYCLES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         idx;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] er;
      logic [7:0] ei;
   } vec_t;

   typedef struct {
      int          w;
      logic [15:0] p;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] a_v [N];
   logic [DW-1:0] b_v [N];
   logic [DW-1:0] ma, mb;
   int            mcnt;
   int            cyc;
   bit            model_en;
   bit            inject_done;
   bit            drop_on_rsp;
   logic [N-1:0]  req_prev;
   int            start_log [$];
   int            start_cyc [$];
   int            rsp_log [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Complex product of packed signed {re,im} nibbles, truncated to RW bits per half.
   function automatic logic [2*RW-1:0] cmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      cpx_op_t x, y;
      int ar, ai, br, bi, re, im;
      x  = a;
      y  = b;
      ar = $signed(x.re);
      ai = $signed(x.im);
      br = $signed(y.re);
      bi = $signed(y.im);
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
      return {re[RW-1:0], im[RW-1:0]};
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int rr_ref(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         bus.req_a[i*DW +: DW] = a_v[i];
         bus.req_b[i*DW +: DW] = b_v[i];
      end
   endtask

   // One clock: advance the multiplier model, then log starts and responses.
   task automatic tick();
      req_prev = bus.req;
      @(posedge clk);
      #1;
      cyc++;
      bus.mult_done = 1'b0;
      if (inject_done) begin
         bus.mult_done = 1'b1;
         bus.mult_real = RW'($urandom);
         bus.mult_imag = RW'($urandom);
         inject_done   = 1'b0;
      end
      if (rst) begin
         mcnt = 0;
      end else if (bus.mult_start && model_en) begin
         mcnt = MULT_LAT - 1;
         ma   = bus.mult_a;
         mb   = bus.mult_b;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            bus.mult_done = 1'b1;
            {bus.mult_real, bus.mult_imag} = cmul(ma, mb);
         end
      end
      if (bus.mult_start) begin
         start_log.push_back(oh_idx(bus.gnt));
         start_cyc.push_back(cyc);
      end
      if (|bus.rsp_valid) begin
         rsp_log.push_back(oh_idx(bus.rsp_valid));
         if (drop_on_rsp) bus.req = bus.req & ~bus.rsp_valid;
      end
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req       = '0;
      bus.mult_done = 1'b0;
      inject_done   = 1'b0;
      mcnt          = 0;
      tick();
      tick();
      rst = 1'b0;
      start_log.delete();
      start_cyc.delete();
      rsp_log.delete();
   endtask

   task automatic wait_rsp(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget && !ok; c++) begin
         tick();
         if (|bus.rsp_valid) ok = 1'b1;
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget && bus.busy; c++) tick();
      check("wait_idle", 32'(bus.busy), 32'd0);
   endtask

   vec_t        vt [8];
   exp_t        exp_q [$];
   exp_t        e;
   logic [15:0] p;
   int          w, ptr_m, done_cnt, busy_cnt, c;
   bit          pending [N];

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst           = 1'b1;
      bus.req       = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.mult_done = 1'b0;
      bus.mult_real = '0;
      bus.mult_imag = '0;
      mcnt          = 0;
      cyc           = 0;
      model_en      = 1'b1;
      inject_done   = 1'b0;
      drop_on_rsp   = 1'b0;

      vt[0] = '{0, 8'h23, 8'h21, 8'h01, 8'h08};
      vt[1] = '{1, 8'h10, 8'h57, 8'h05, 8'h07};
      vt[2] = '{2, 8'hF0, 8'h34, 8'hFD, 8'hFC};
      vt[3] = '{3, 8'h01, 8'h01, 8'hFF, 8'h00};
      vt[4] = '{0, 8'h88, 8'h88, 8'h00, 8'h80};
      vt[5] = '{1, 8'h77, 8'h7F, 8'h38, 8'h2A};
      vt[6] = '{2, 8'h8F, 8'h21, 8'hF1, 8'hF6};
      vt[7] = '{3, 8'h00, 8'hFF, 8'h00, 8'h00};

      // reset state
      tick();
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_mult_start", 32'(bus.mult_start), 0);
      check("rst_mult_a", 32'(bus.mult_a), 0);
      check("rst_mult_b", 32'(bus.mult_b), 0);
      check("rst_rsp_real", 32'(bus.rsp_real), 0);
      check("rst_rsp_imag", 32'(bus.rsp_imag), 0);
      check("rst_rsp_err", 32'(bus.rsp_err), 0);
      do_reset();

      // single-requester vectors
      for (int v = 0; v < 8; v++) begin
         a_v[vt[v].idx] = vt[v].a;
         b_v[vt[v].idx] = vt[v].b;
         drive_ops();
         bus.req[vt[v].idx] = 1'b1;
         tick();
         check("vec_gnt", 32'(bus.gnt), 32'(1 << vt[v].idx));
         check("vec_start", 32'(bus.mult_start), 1);
         check("vec_mult_a", 32'(bus.mult_a), 32'(vt[v].a));
         check("vec_mult_b", 32'(bus.mult_b), 32'(vt[v].b));
         tick();
         check("vec_start_pulse", 32'(bus.mult_start), 0);
         check("vec_gnt_held", 32'(bus.gnt), 32'(1 << vt[v].idx));
         wait_rsp("vec_rsp_seen", 20);
         check("vec_rsp_valid", 32'(bus.rsp_valid), 32'(1 << vt[v].idx));
         check("vec_rsp_real", 32'(bus.rsp_real), 32'(vt[v].er));
         check("vec_rsp_imag", 32'(bus.rsp_imag), 32'(vt[v].ei));
         check("vec_rsp_err", 32'(bus.rsp_err), 0);
         bus.req[vt[v].idx] = 1'b0;
         tick();
         check("vec_idle_after", 32'(bus.busy), 0);
      end

      // all four requesting, each drops after its response
      do_reset();
      drop_on_rsp = 1'b1;
      bus.req     = 4'b1111;
      for (c = 0; c < 60 && rsp_log.size() < 4; c++) tick();
      drop_on_rsp = 1'b0;
      check("all4_rsp_count", 32'(rsp_log.size()), 4);
      for (int k = 0; k < 4; k++) begin
         check("all4_grant_order", 32'(start_log[k]), 32'(k));
         check("all4_rsp_order", 32'(rsp_log[k]), 32'(k));
      end
      wait_idle(20);

      // req0 and req2 held permanently alternate
      do_reset();
      bus.req = 4'b0101;
      for (c = 0; c < 80 && start_log.size() < 5; c++) tick();
      check("alt_start_count", 32'(start_log.size() >= 5), 1);
      for (int k = 0; k < 5; k++)
         check("alt_grant", 32'(start_log[k]), 32'((k % 2) * 2));
      bus.req = '0;
      wait_idle(20);

      // single persistent requester is re-granted back to back
      do_reset();
      bus.req = 4'b0100;
      for (c = 0; c < 80 && start_log.size() < 4; c++) tick();
      check("persist_start_count", 32'(start_log.size() >= 4), 1);
      check("persist_first_latency", 32'(start_cyc[0] - (cyc - c) ), 1);
      for (int k = 0; k < 3; k++) begin
         check("persist_grant", 32'(start_log[k]), 2);
         check("persist_period", 32'(start_cyc[k+1] - start_cyc[k]), 32'(MULT_LAT + 2));
      end
      bus.req = '0;
      wait_idle(20);

      // stray mult_done in IDLE and ISSUE
      do_reset();
      inject_done = 1'b1;
      tick();
      check("idle_done_busy", 32'(bus.busy), 0);
      check("idle_done_rsp", 32'(bus.rsp_valid), 0);
      tick();
      check("idle_done_busy2", 32'(bus.busy), 0);
      check("idle_done_rsp2", 32'(bus.rsp_valid), 0);
      a_v[1] = 8'h23;
      b_v[1] = 8'h21;
      drive_ops();
      bus.req[1]  = 1'b1;
      inject_done = 1'b1;
      tick();
      check("issue_done_start", 32'(bus.mult_start), 1);
      tick();
      check("issue_done_busy", 32'(bus.busy), 1);
      check("issue_done_rsp", 32'(bus.rsp_valid), 0);
      check("issue_done_gnt", 32'(bus.gnt), 32'b0010);
      wait_rsp("issue_done_rsp_seen", 20);
      check("issue_done_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
      check("issue_done_real", 32'(bus.rsp_real), 32'h01);
      check("issue_done_imag", 32'(bus.rsp_imag), 32'h08);
      bus.req = '0;
      wait_idle(20);

      // reset mid-WAIT clears outputs at once and returns ptr to 0
      do_reset();
      bus.req = 4'b0010;
      wait_rsp("mid_pre_rsp", 20);
      bus.req = 4'b1000;
      tick();
      tick();
      tick();
      check("mid_busy_before", 32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_gnt", 32'(bus.gnt), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_start", 32'(bus.mult_start), 0);
      check("mid_rst_rsp", 32'(bus.rsp_valid), 0);
      bus.req = '0;
      tick();
      tick();
      rst     = 1'b0;
      bus.req = 4'b0110;
      tick();
      check("mid_after_gnt", 32'(bus.gnt), 32'b0010);
      wait_rsp("mid_after_rsp_seen", 20);
      check("mid_after_rsp", 32'(bus.rsp_valid), 32'b0010);
      bus.req = '0;
      wait_idle(20);

      // multiplier that never answers
      do_reset();
      model_en = 1'b0;
      bus.req  = 4'b0001;
      tick();
      check("nodone_start", 32'(bus.mult_start), 1);
`ifdef CMULT_ARB_WDOG_EN
      for (c = 1; c <= 100; c++) begin
         tick();
         if (|bus.rsp_valid) break;
      end
      check("wdog_cycles", 32'(c), 65);
      check("wdog_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
      check("wdog_err", 32'(bus.rsp_err), 1);
      check("wdog_real", 32'(bus.rsp_real), 0);
      check("wdog_imag", 32'(bus.rsp_imag), 0);
      bus.req     = '0;
      inject_done = 1'b1;
      tick();
      tick();
      check("wdog_late_done_busy", 32'(bus.busy), 0);
      check("wdog_late_done_rsp", 32'(bus.rsp_valid), 0);
`else
      busy_cnt = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (bus.busy && bus.rsp_valid == '0) busy_cnt++;
      end
      check("nodone_busy_held", 32'(busy_cnt), 200);
      check("nodone_err", 32'(bus.rsp_err), 0);
`endif
      model_en = 1'b1;

      // randomized traffic against a round-robin scoreboard
      do_reset();
      ptr_m    = 0;
      done_cnt = 0;
      for (int i = 0; i < N; i++) pending[i] = 1'b0;
      for (int t = 0; t < 3200; t++) begin
         tick();
         if (bus.mult_start) begin
            w = rr_ref(req_prev, ptr_m);
            check("rnd_winner_valid", 32'(w >= 0), 1);
            check("rnd_no_overlap", 32'(exp_q.size()), 0);
            if (w >= 0) begin
               check("rnd_gnt", 32'(bus.gnt), 32'(1 << w));
               check("rnd_mult_a", 32'(bus.mult_a), 32'(a_v[w]));
               check("rnd_mult_b", 32'(bus.mult_b), 32'(b_v[w]));
               exp_q.push_back('{w, cmul(a_v[w], b_v[w])});
            end
         end
         if (|bus.rsp_valid) begin
            check("rnd_rsp_expected", 32'(exp_q.size()), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.w));
               check("rnd_rsp_real", 32'(bus.rsp_real), 32'(e.p[15:8]));
               check("rnd_rsp_imag", 32'(bus.rsp_imag), 32'(e.p[7:0]));
               check("rnd_rsp_err", 32'(bus.rsp_err), 0);
               ptr_m          = (e.w + 1) % N;
               pending[e.w]   = 1'b0;
               bus.req[e.w]   = 1'b0;
               done_cnt++;
            end
         end
         if (t < 3000) begin
            for (int i = 0; i < N; i++) begin
               if (!pending[i]) begin
                  if ($urandom_range(0, 3) == 0) begin
                     pending[i] = 1'b1;
                     a_v[i]     = DW'($urandom);
                     b_v[i]     = DW'($urandom);
                     bus.req[i] = 1'b1;
                  end
               end else if (bus.gnt[i] && bus.req[i] && $urandom_range(0, 7) == 0) begin
                  bus.req[i] = 1'b0;
               end
            end
            drive_ops();
            if (!bus.busy && $urandom_range(0, 15) == 0) inject_done = 1'b1;
         end
      end
      check("rnd_drained", 32'(bus.busy), 0);
      check("rnd_no_leftover", 32'(exp_q.size()), 0);
      check("rnd_throughput", 32'(done_cnt > 100), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
